// File: rtl/divisor_unit_pkg.sv
// ============================================================================
// Module      : divisor_unit_pkg
// Description : Shared types and helpers for the iterative restoring divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package divisor_unit_pkg;

    localparam int PARALLELISM_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_e;

    // Bits needed to count down from n-1 to 0.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/divisor_step.sv
// ============================================================================
// Module      : divisor_step
// Description : One combinational restoring-division iteration.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module divisor_step #(
    parameter int width = 32
) (
    input  logic [width-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [width-1:0] dsr_mag,
    output logic [width-1:0] rem_out,
    output logic             q_bit
);

    logic [width:0] shifted;
    logic [width:0] trial;

    // rem_in < dsr_mag keeps |trial| below 2^width, so trial[width] is an exact sign bit.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {1'b0, dsr_mag};
        q_bit   = ~trial[width];
        rem_out = q_bit ? trial[width-1:0] : shifted[width-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/divisor_unit.sv
// ============================================================================
// Module      : divisor_unit
// Description : Multi-cycle signed/unsigned restoring divider, one bit per clock.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module divisor_unit
    import divisor_unit_pkg::*;
#(
    parameter int parallelism = PARALLELISM_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid,
    input  logic                   usigned,
    input  logic [parallelism-1:0] divisor,
    input  logic [parallelism-1:0] dividend,
    output logic [parallelism-1:0] reminder,
    output logic [parallelism-1:0] quotient,
    output logic                   res_ready
);

    localparam int CNT_W = cnt_width(parallelism);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [parallelism-1:0] rem_q, rem_d;
    logic [parallelism-1:0] dvd_q, dvd_d;
    logic [parallelism-1:0] dsr_q, dsr_d;
    logic                   q_neg_q, q_neg_d;
    logic                   r_neg_q, r_neg_d;
    logic                   dz_q, dz_d;
    logic [parallelism-1:0] quotient_q, quotient_d;
    logic [parallelism-1:0] reminder_q, reminder_d;
    logic                   res_ready_q, res_ready_d;

    logic [parallelism-1:0] step_rem;
    logic                   step_q;
    logic                   is_signed;

    divisor_step #(
        .width(parallelism)
    ) u_step (
        .rem_in (rem_q),
        .dvd_bit(dvd_q[parallelism-1]),
        .dsr_mag(dsr_q),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        reminder_d  = reminder_q;
        res_ready_d = 1'b0;
        is_signed   = ~usigned;

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = DIVIDE;
                    cnt_d   = CNT_W'(parallelism - 1);
                    rem_d   = '0;
                    // Most-negative magnitude stays 2^(parallelism-1) read as unsigned.
                    dvd_d   = (is_signed && dividend[parallelism-1]) ? -dividend : dividend;
                    dsr_d   = (is_signed && divisor[parallelism-1])  ? -divisor  : divisor;
                    q_neg_d = is_signed & (dividend[parallelism-1] ^ divisor[parallelism-1]);
                    r_neg_d = is_signed & dividend[parallelism-1];
                    dz_d    = (divisor == '0);
                end
            end
            DIVIDE: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[parallelism-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Divide-by-zero remainder is already the dividend; only the quotient needs overriding.
                quotient_d  = dz_q ? '1 : (q_neg_q ? -dvd_q : dvd_q);
                reminder_d  = r_neg_q ? -rem_q : rem_q;
                res_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            reminder_q  <= '0;
            res_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            reminder_q  <= reminder_d;
            res_ready_q <= res_ready_d;
        end
    end

    assign quotient  = quotient_q;
    assign reminder  = reminder_q;
    assign res_ready = res_ready_q;

endmodule

`default_nettype wire

// File: tb/tb_divisor_unit.sv
// ============================================================================
// Module      : tb_divisor_unit
// Description : Directed scoreboard bench for divisor_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_divisor_unit;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic         usigned = 1'b0;
    logic [W-1:0] divisor = '0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] reminder;
    logic [W-1:0] quotient;
    logic         res_ready;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   cap_cyc = 0;

    divisor_unit #(
        .parallelism(W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid    (valid),
        .usigned  (usigned),
        .divisor  (divisor),
        .dividend (dividend),
        .reminder (reminder),
        .quotient (quotient),
        .res_ready(res_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic us);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else if (!us && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = a;
            e.r = '0;
        end else if (us) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            e.q = $signed(a) / $signed(b);
            e.r = $signed(a) % $signed(b);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic us, input bit push);
        if (push) sb.push_back(model(a, b, us));
        @(negedge clk);
        dividend = a;
        divisor  = b;
        usigned  = us;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        cap_cyc  = cyc;
        valid    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        usigned  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(input string tag);
        int   n;
        exp_t e;
        logic [W-1:0] q_seen;
        n = 0;
        while (res_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_ready"}, {31'd0, res_ready}, 32'd1);
        if (res_ready === 1'b1) begin
            chk({tag, "_latency"}, 32'(cyc - cap_cyc), 32'(W + 1));
            chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({tag, "_quotient"}, quotient, e.q);
                chk({tag, "_reminder"}, reminder, e.r);
            end
            q_seen = quotient;
            @(posedge clk);
            #1;
            chk({tag, "_pulse_end"}, {31'd0, res_ready}, 32'd0);
            chk({tag, "_hold"}, quotient, q_seen);
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic us, input string tag);
        issue(a, b, us, 1'b1);
        wait_result(tag);
    endtask

    task automatic no_pulse(input int cycles, input string tag);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (res_ready === 1'b1) pulses++;
        end
        chk(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        #3;
        chk("rst_quotient", quotient, '0);
        chk("rst_reminder", reminder, '0);
        chk("rst_ready", {31'd0, res_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run(32'h0035_CC80, 32'hF035_9577, 1'b0, "spec_signed");
        run(32'd100,       32'd7,         1'b1, "u_100_7");
        run(32'hFFFF_FFFF, 32'h0000_0010, 1'b1, "u_max_16");
        run(32'hFFFF_FFF9, 32'h0000_0002, 1'b0, "s_m7_2");
        run(32'h0000_0007, 32'hFFFF_FFFE, 1'b0, "s_7_m2");
        run(32'h1234_5678, 32'h0000_0000, 1'b0, "s_div0");
        run(32'h1234_5678, 32'h0000_0000, 1'b1, "u_div0");
        run(32'hFFFF_FFF9, 32'h0000_0000, 1'b0, "s_neg_div0");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s_overflow");
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "u_min_max");
        run(32'h8000_0000, 32'h0000_0003, 1'b0, "s_min_3");
        run(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, "s_m100_m7");

        // A second valid while dividing must be ignored.
        issue(32'h0000_1000, 32'h0000_0003, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        dividend = 32'h0000_0055;
        divisor  = 32'h0000_0002;
        usigned  = 1'b1;
        valid    = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
        wait_result("hs_first");
        no_pulse(40, "hs_single_pulse");

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            run(a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        issue(32'h0000_FFFF, 32'h0000_0005, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_quotient", quotient, '0);
        chk("midrst_reminder", reminder, '0);
        chk("midrst_ready", {31'd0, res_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        no_pulse(40, "midrst_no_pulse");
        run(32'h0000_FFFF, 32'h0000_0005, 1'b1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
